// File: rtl/bit_scan16_pkg.sv
// bit_scan_pkg: shared widths, FSM states and helpers for the set-bit scanner
package bit_scan_pkg;
    localparam int WIDTH = 16;
    localparam int IDX_W = $clog2(WIDTH);
    typedef enum logic {IDLE, EMIT} state_t;
    function automatic logic onehot_or_zero(input logic [WIDTH-1:0] v);
        return (v & (v - WIDTH'(1))) == '0;
    endfunction
endpackage

// File: rtl/bit_scan16_if.sv
// bit_scan16_if: input word handshake plus output index beat handshake
interface bit_scan16_if;
    import bit_scan_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;
    logic             busy;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero, busy
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero, busy
    );
endinterface

// File: rtl/bit_scan16_prio_enc16.sv
// prio_enc16: combinational lowest-set-bit priority encoder
module prio_enc16
    import bit_scan_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (vec[i]) begin
                idx = IDX_W'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/bit_scan16.sv
// bit_scan16: emits the index of every set bit of an accepted word, lowest first
module bit_scan16
    import bit_scan_pkg::*;
(
    input logic         clk,
    input logic         rst,
    bit_scan16_if.slave bus
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] rem;
    logic             zero_q;
    logic [IDX_W-1:0] enc_idx;
    logic             found;
    logic             emit;
    prio_enc16 u_enc (.vec(rem), .idx(enc_idx), .found(found));
    assign emit = state == EMIT;
    always_comb begin
        bus.in_ready  = !emit;
        bus.out_valid = emit;
        bus.busy      = emit;
        bus.out_zero  = emit && zero_q;
        bus.out_idx   = (emit && found && !zero_q) ? enc_idx : '0;
        bus.out_last  = emit && (zero_q || onehot_or_zero(rem));
        state_nx      = state;
        if (!emit && bus.in_valid)
            state_nx = EMIT;
        else if (emit && bus.out_ready && bus.out_last)
            state_nx = IDLE;
    end
    // accept and beat handshakes are mutually exclusive: each exists in only one state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.in_valid && bus.in_ready) begin
                rem    <= bus.in_data;
                zero_q <= bus.in_data == '0;
            end else if (bus.out_valid && bus.out_ready)
                rem <= rem & ~(WIDTH'(1) << bus.out_idx);
        end
    end
endmodule

// File: doc/bit_scan16.md
# bit_scan16

Sequential set-bit scanner: accepts a 16-bit word over a valid/ready handshake and emits the index of every set bit, lowest first, one per output handshake. It performs the inverse job of the `or16` reduction. `or16` collapses a vector to a single "any bit set" flag; this block expands a vector back into the positions that produced the flag. It sits between status/interrupt-style bit vectors and consumers that service one source at a time.

## Interface
- `WIDTH`, 16, input vector width; fixed at 16 in this revision.
- `IDX_W`, `$clog2(WIDTH)` = 4, index width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  `in_data` is offered
- `in_ready`  out  1  block can accept a word
- `in_data`  in  16  word to scan
- `out_valid`  out  1  `out_idx`/`out_last`/`out_zero` valid
- `out_ready`  in  1  consumer takes the current beat
- `out_idx`  out  4  index of lowest remaining set bit
- `out_last`  out  1  current beat is the final beat of this word
- `out_zero`  out  1  accepted word was 0x0000 (single beat, `out_idx`=0)
- `busy`  out  1  scan in progress (state ≠ IDLE)

## Operation
- States: IDLE, EMIT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: latch `in_data` into `rem` and set `zero_q` = (`in_data`==0). Go to EMIT.
- EMIT:
  - `in_ready`=0, `out_valid`=1.
  - `out_idx` = position of lowest set bit of `rem`, or 0 if `zero_q`.
  - `out_last` = `zero_q` OR (`rem` has exactly one bit set).
  - `out_zero` = `zero_q`.
- On `out_valid && out_ready` in EMIT:
  - Clear bit `out_idx` in `rem`.
  - If `out_last`, go to IDLE; otherwise stay in EMIT.
- A word with k set bits (k≥1) produces exactly k beats; a zero word produces exactly 1 beat.
- Beats are emitted in strictly ascending index order.
- Outputs are stable while `out_valid && !out_ready` (AXI-style hold); `rem` does not change.
- `in_data` is sampled only at the accept edge; later changes are ignored.
- Arithmetic: `rem` is 16 bits. The clear mask is `~(16'h1 << out_idx)`. No wrap is possible because the index never exceeds 15.

## Timing
- Reset values:
  - state=IDLE, `rem`=0, `zero_q`=0.
  - `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_last`=0, `out_zero`=0, `busy`=0.
- Latency: the first beat is valid in the cycle after the accept edge (1 cycle).
- Throughput:
  - Consecutive beats can be zero-bubble: with `out_ready` held high, the next index appears the cycle after each handshake.
  - Back-to-back words: `in_ready` returns to 1 the cycle after the last handshake. A k-bit word therefore occupies at least k+1 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.
- `rst` asserted mid-EMIT:
  - On the next edge, the block is back in IDLE with reset values.
  - Any pending beats are discarded.
  - `rst` has priority over every handshake in the same cycle.
- `in_valid` asserted in EMIT: ignored (`in_ready`=0); the upstream holds the word.

## Structure
- Package `bit_scan_pkg`:
  - `WIDTH`, `IDX_W` constants.
  - `state_t` enum {IDLE, EMIT}.
  - Function `onehot_or_zero(logic [WIDTH-1:0])` for `out_last`.
- Sub-module `prio_enc16`: combinational lowest-set-bit priority encoder.
  - Inputs: `vec[15:0]`.
  - Outputs: `idx[3:0]`, `found`.
  - Instantiated once on `rem`.
- Top: state register, `rem`/`zero_q` registers, clear logic, output decode.

## Test plan
- Reset then `in_data`=0x0000 accepted → next cycle one beat: `out_zero`=1, `out_idx`=0, `out_last`=1. Then `in_ready`=1.
- Walking one: for each i in 0..15, `in_data`=1<<i → exactly one beat with `out_idx`=i, `out_last`=1, `out_zero`=0. Each word takes 2 cycles with `out_ready` held at 1.
- `in_data`=0xA5A5 with `out_ready`=1 → `out_idx` sequence 0,2,5,7,8,10,13,15 on consecutive cycles. `out_last`=1 only on 15.
- Backpressure: `in_data`=0x8001 with `out_ready`=0 for 3 cycles → `out_idx`=0, `out_last`=0 held stable. Raise `out_ready` → next beat `out_idx`=15, `out_last`=1.
- Reset mid-scan: `in_data`=0xFFFF, assert `rst` after the 4th beat → next cycle `out_valid`=0, `in_ready`=1, `busy`=0. A new word 0x0010 then yields a single `out_idx`=4.
- `in_valid` toggling during EMIT with different `in_data` → no extra accepts. The beat sequence matches only the originally latched word.
